// File: rtl/keypad_matrix_scanner.sv
// 4x4 key matrix scanner: rotates a one-hot-low column drive, debounces whole-matrix snapshots
// and strobes a key code per clean single-key press. Auto-repeat under KEYPAD_AUTOREPEAT_EN.
module keypad_matrix_scanner #(
  parameter int unsigned SCAN_DIV           = 1000,
  parameter int unsigned DEBOUNCE_SCANS     = 4,
  parameter int unsigned REPEAT_DELAY_SCANS = 50,
  parameter int unsigned REPEAT_RATE_SCANS  = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic [3:0] keyCode,
  output logic       keyValid,
  output logic       keyHeld
);
  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned StW  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [StW-1:0]  StMax   = StW'(DEBOUNCE_SCANS);

  logic [3:0]      r_rows_meta, r_rows_sync;
  logic [DivW-1:0] r_div;
  logic [3:0]      r_columns;
  logic [15:0]     r_snap, r_prev, r_deb;
  logic [StW-1:0]  r_stable;
  logic            r_scan_end;
  logic [3:0]      r_key_code;
  logic            r_key_valid, r_key_held;

  logic            w_term;
  logic [1:0]      w_col;
  logic [3:0]      w_col_next;
  logic [StW-1:0]  w_stable_next;
  logic            w_deb_load, w_deb_change, w_one_hot, w_press, w_repeat;
  logic [15:0]     w_deb_next;
  logic [3:0]      w_code;

  assign w_term = (r_div == DivLast);

  always_comb begin
    w_col      = 2'd0;
    w_col_next = 4'b1110;
    case (r_columns)
      4'b1110: begin w_col = 2'd0; w_col_next = 4'b1101; end
      4'b1101: begin w_col = 2'd1; w_col_next = 4'b1011; end
      4'b1011: begin w_col = 2'd2; w_col_next = 4'b0111; end
      4'b0111: begin w_col = 2'd3; w_col_next = 4'b1110; end
      default: ;
    endcase
  end

  // Snapshot bit col*4+row maps to key code {row, col}.
  always_comb begin
    w_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (r_snap[i]) w_code = {2'(i % 4), 2'(i / 4)};
    end
  end

  assign w_stable_next = (r_snap != r_prev) ? StW'(1) :
                         (r_stable == StMax) ? StMax : r_stable + StW'(1);
  assign w_deb_load    = r_scan_end && (w_stable_next == StMax);
  assign w_deb_next    = w_deb_load ? r_snap : r_deb;
  assign w_deb_change  = w_deb_load && (r_snap != r_deb);
  assign w_one_hot     = (r_snap != 16'h0) && ((r_snap & (r_snap - 16'd1)) == 16'h0);
  assign w_press       = w_deb_load && (r_deb == 16'h0) && w_one_hot;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                                   REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  logic            r_rep_active, r_rep_first;
  logic [RepW-1:0] r_rep_cnt;
  logic [RepW-1:0] w_rep_target, w_rep_cnt_inc;

  assign w_rep_target  = r_rep_first ? RepW'(REPEAT_DELAY_SCANS) : RepW'(REPEAT_RATE_SCANS);
  assign w_rep_cnt_inc = r_rep_cnt + RepW'(1);
  assign w_repeat      = r_scan_end && r_rep_active && !w_deb_change &&
                         (w_rep_cnt_inc == w_rep_target);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rep_active <= 1'b0;
      r_rep_first  <= 1'b1;
      r_rep_cnt    <= '0;
    end else if (w_deb_change) begin
      // Only a freshly accepted press arms the repeat counter.
      r_rep_active <= w_press;
      r_rep_first  <= 1'b1;
      r_rep_cnt    <= '0;
    end else if (r_scan_end && r_rep_active) begin
      if (w_repeat) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b0;
      end else begin
        r_rep_cnt   <= w_rep_cnt_inc;
      end
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rows_meta <= 4'hF;
      r_rows_sync <= 4'hF;
      r_div       <= '0;
      r_columns   <= 4'b1110;
      r_snap      <= 16'h0;
      r_prev      <= 16'h0;
      r_deb       <= 16'h0;
      r_stable    <= '0;
      r_scan_end  <= 1'b0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_rows_meta <= rows;
      r_rows_sync <= r_rows_meta;
      if (w_term) begin
        r_div     <= '0;
        r_columns <= w_col_next;
        r_snap[{w_col, 2'b00} +: 4] <= ~r_rows_sync;
      end else begin
        r_div     <= r_div + DivW'(1);
      end
      // Snapshot is complete the cycle after column 3 is sampled.
      r_scan_end <= w_term && (r_columns == 4'b0111);
      if (r_scan_end) begin
        r_stable <= w_stable_next;
        r_prev   <= r_snap;
      end
      r_deb       <= w_deb_next;
      r_key_held  <= |w_deb_next;
      r_key_valid <= w_press | w_repeat;
      if (w_press) r_key_code <= w_code;
    end
  end

  assign columns  = r_columns;
  assign keyCode  = r_key_code;
  assign keyValid = r_key_valid;
  assign keyHeld  = r_key_held;

endmodule
